// File: rtl/axi_rd_responder.sv
// -----------------------------------------------------------------------------
// axi_rd_responder
//
// AXI4 read-channel responder. Accepts one AR request at a time, waits a
// programmable number of cycles, then serves the burst one beat at a time
// from a synchronous-read backing memory (data valid one cycle after mem_ren).
// Supports FIXED / INCR / WRAP bursts. Out-of-window addresses, the reserved
// burst type and illegal WRAP lengths are answered with SLVERR and never touch
// the memory.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   arvalid/arready     read address handshake
//   araddr/arlen/arburst start byte address, beats-1, burst type
//   rvalid/rready       read data handshake
//   rdata/rresp/rlast   beat data, response (00 OKAY / 10 SLVERR), last flag
//   mem_ren/mem_raddr   backing memory read strobe and word-aligned address
//   mem_rdata           backing memory data, one cycle after mem_ren
// -----------------------------------------------------------------------------
module axi_rd_responder #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                LATENCY  = 2,
    parameter logic [ADDR_W-1:0] MEM_BASE = 32'h8000_0000,
    parameter logic [ADDR_W-1:0] MEM_SIZE = 32'h0800_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arvalid,
    output logic              arready,
    input  logic [ADDR_W-1:0] araddr,
    input  logic [7:0]        arlen,
    input  logic [1:0]        arburst,
    output logic              rvalid,
    input  logic              rready,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        READ = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [1:0]        BURST_FIXED = 2'b00;
    localparam logic [1:0]        BURST_WRAP  = 2'b10;
    localparam logic [1:0]        BURST_RSVD  = 2'b11;
    localparam logic [1:0]        RESP_OKAY   = 2'b00;
    localparam logic [1:0]        RESP_SLVERR = 2'b10;
    localparam logic [ADDR_W-1:0] BEAT_STEP   = ADDR_W'(DATA_W / 8);
    // Window end computed one bit wider so BASE+SIZE at the top of the
    // address space does not overflow.
    localparam logic [ADDR_W:0]   MEM_END     = {1'b0, MEM_BASE} + {1'b0, MEM_SIZE};
    localparam logic [15:0]       WAIT_LOAD   = 16'(LATENCY);

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [7:0]          len_reg, len_next;
    logic [1:0]          burst_reg, burst_next;
    logic [7:0]          beat_reg, beat_next;
    logic [15:0]         wait_reg, wait_next;
    logic [DATA_W-1:0]   rdata_reg, rdata_next;
    logic                first_reg, first_next;

    logic                in_range;
    logic                wrap_len_ok;
    logic                beat_err;
    logic [ADDR_W-1:0]   wrap_mask;
    logic [ADDR_W-1:0]   addr_inc;
    logic [ADDR_W-1:0]   addr_adv;

    // Per-beat error decision, always on the current beat address.
    always_comb begin
        in_range    = ({1'b0, addr_reg} >= {1'b0, MEM_BASE}) && ({1'b0, addr_reg} < MEM_END);
        wrap_len_ok = (len_reg == 8'd1) || (len_reg == 8'd3) ||
                      (len_reg == 8'd7) || (len_reg == 8'd15);
        beat_err    = !in_range || (burst_reg == BURST_RSVD) ||
                      ((burst_reg == BURST_WRAP) && !wrap_len_ok);
    end

    // Next beat address. For legal WRAP lengths (len+1)*4-1 is simply
    // {len,2'b11}, so the low bits roll over inside the wrap window and the
    // bits above it are held.
    always_comb begin
        wrap_mask = {{(ADDR_W-10){1'b0}}, len_reg, 2'b11};
        addr_inc  = addr_reg + BEAT_STEP;
        case (burst_reg)
            BURST_FIXED: addr_adv = addr_reg;
            BURST_WRAP:  addr_adv = (addr_reg & ~wrap_mask) | (addr_inc & wrap_mask);
            default:     addr_adv = addr_inc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            addr_reg  <= '0;
            len_reg   <= '0;
            burst_reg <= '0;
            beat_reg  <= '0;
            wait_reg  <= '0;
            rdata_reg <= '0;
            first_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            len_reg   <= len_next;
            burst_reg <= burst_next;
            beat_reg  <= beat_next;
            wait_reg  <= wait_next;
            rdata_reg <= rdata_next;
            first_reg <= first_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        len_next   = len_reg;
        burst_next = burst_reg;
        beat_next  = beat_reg;
        wait_next  = wait_reg;
        rdata_next = rdata_reg;
        first_next = 1'b0;

        arready    = (state_reg == IDLE) && !rst;
        rvalid     = 1'b0;
        rresp      = RESP_OKAY;
        rlast      = 1'b0;
        rdata      = rdata_reg;
        mem_ren    = 1'b0;
        mem_raddr  = addr_reg;

        case (state_reg)
            IDLE: begin
                if (arvalid && arready) begin
                    addr_next  = {araddr[ADDR_W-1:2], 2'b00};
                    len_next   = arlen;
                    burst_next = arburst;
                    beat_next  = '0;
                    wait_next  = WAIT_LOAD;
                    state_next = (LATENCY > 0) ? WAIT : READ;
                end
            end
            WAIT: begin
                wait_next = wait_reg - 16'd1;
                if (wait_reg <= 16'd1) begin
                    state_next = READ;
                end
            end
            READ: begin
                mem_ren    = !beat_err;
                first_next = 1'b1;
                state_next = RESP;
            end
            RESP: begin
                rvalid = 1'b1;
                rresp  = beat_err ? RESP_SLVERR : RESP_OKAY;
                rlast  = (beat_reg == len_reg);
                // Memory data is only present in the first RESP cycle; it is
                // captured then and replayed from rdata_reg during a stall.
                if (first_reg) begin
                    rdata = beat_err ? '0 : mem_rdata;
                end
                rdata_next = rdata;
                if (rready) begin
                    if (rlast) begin
                        state_next = IDLE;
                    end else begin
                        beat_next  = beat_reg + 8'd1;
                        addr_next  = addr_adv;
                        state_next = READ;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi_rd_responder.sv
// -----------------------------------------------------------------------------
// Directed testbench for axi_rd_responder (default parameters, LATENCY=2).
// The backing memory returns its own word address as data.
// -----------------------------------------------------------------------------
module tb_axi_rd_responder;

    logic        clk;
    logic        rst;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [1:0]  arburst;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        mem_ren;
    logic [31:0] mem_raddr;
    logic [31:0] mem_rdata;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] ren_q[$];
    logic [31:0] bd[32];
    logic [1:0]  br[32];
    logic        bl[32];
    int          nb;

    axi_rd_responder dut (
        .clk       (clk),
        .rst       (rst),
        .arvalid   (arvalid),
        .arready   (arready),
        .araddr    (araddr),
        .arlen     (arlen),
        .arburst   (arburst),
        .rvalid    (rvalid),
        .rready    (rready),
        .rdata     (rdata),
        .rresp     (rresp),
        .rlast     (rlast),
        .mem_ren   (mem_ren),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memory model: data = word address, one cycle later.
    initial mem_rdata = 32'h0;
    always @(posedge clk) begin
        if (mem_ren) begin
            mem_rdata <= mem_raddr;
            ren_q.push_back(mem_raddr);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rvalid(input string tag);
        for (int i = 0; i < 50 && !rvalid; i++) tick();
        chk(tag, rvalid, 1'b1);
    endtask

    task automatic issue_ar(input logic [31:0] a, input logic [7:0] l, input logic [1:0] b);
        ren_q.delete();
        araddr  = a;
        arlen   = l;
        arburst = b;
        arvalid = 1'b1;
        for (int i = 0; i < 50 && !arready; i++) tick();
        tick();
        arvalid = 1'b0;
        $display("AR addr=%08h len=%0d burst=%0d", a, l, b);
    endtask

    // Issue a burst with rready held high and record every beat.
    task automatic burst(input logic [31:0] a, input logic [7:0] l, input logic [1:0] b);
        logic done;
        issue_ar(a, l, b);
        nb   = 0;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            if (rvalid) begin
                bd[nb] = rdata;
                br[nb] = rresp;
                bl[nb] = rlast;
                $display("R beat=%0d data=%08h resp=%0d last=%0d", nb, rdata, rresp, rlast);
                nb++;
                if (rlast || nb == 32) done = 1'b1;
            end
            tick();
        end
        chk("burst_completes", done, 1'b1);
    endtask

    function automatic logic [31:0] ren_at(input int k);
        return (ren_q.size() > k) ? ren_q[k] : 32'hDEAD_BEEF;
    endfunction

    initial begin
        rst     = 1'b1;
        arvalid = 1'b0;
        araddr  = 32'h0;
        arlen   = 8'h0;
        arburst = 2'b00;
        rready  = 1'b1;
        repeat (3) tick();

        // Reset state
        chk("rst_arready", arready, 1'b0);
        chk("rst_rvalid",  rvalid,  1'b0);
        chk("rst_rlast",   rlast,   1'b0);
        chk("rst_mem_ren", mem_ren, 1'b0);
        chk("rst_rresp",   rresp,   2'b00);
        chk("rst_rdata",   rdata,   32'h0);
        rst = 1'b0;
        #1;
        chk("idle_arready", arready, 1'b1);
        tick();

        // INCR len=3 at 0x8000_0010: exact cycle timing (T = AR cycle)
        araddr  = 32'h8000_0010;
        arlen   = 8'd3;
        arburst = 2'b01;
        arvalid = 1'b1;
        #1;
        chk("t1_arready_T", arready, 1'b1);
        tick();                                   // T+1
        arvalid = 1'b0;
        $display("AR addr=80000010 len=3 burst=1");
        chk("t1_arready_busy", arready, 1'b0);
        chk("t1_rvalid_T1", rvalid, 1'b0);
        tick();                                   // T+2
        chk("t1_mem_ren_T2", mem_ren, 1'b0);
        tick();                                   // T+3: READ
        chk("t1_mem_ren_T3",   mem_ren,   1'b1);
        chk("t1_mem_raddr_T3", mem_raddr, 32'h8000_0010);
        tick();                                   // T+4: first rvalid
        for (int b = 0; b < 4; b++) begin
            chk("t1_rvalid", rvalid, 1'b1);
            chk("t1_rdata",  rdata,  32'h8000_0010 + 32'(4 * b));
            chk("t1_rresp",  rresp,  2'b00);
            chk("t1_rlast",  rlast,  (b == 3));
            $display("R beat=%0d data=%08h resp=%0d last=%0d", b, rdata, rresp, rlast);
            tick();
            if (b < 3) begin
                chk("t1_gap_rvalid",  rvalid,    1'b0);
                chk("t1_gap_raddr",   mem_raddr, 32'h8000_0014 + 32'(4 * b));
                tick();
            end else begin
                chk("t1_end_arready", arready, 1'b1);
                chk("t1_end_rvalid",  rvalid,  1'b0);
            end
        end
        tick();

        // WRAP len=3 at 0x8000_0038
        burst(32'h8000_0038, 8'd3, 2'b10);
        chk("wrap_nbeats", nb, 4);
        chk("wrap_nren",   ren_q.size(), 4);
        chk("wrap_ren0", ren_at(0), 32'h8000_0038);
        chk("wrap_ren1", ren_at(1), 32'h8000_003C);
        chk("wrap_ren2", ren_at(2), 32'h8000_0030);
        chk("wrap_ren3", ren_at(3), 32'h8000_0034);
        chk("wrap_d2",   bd[2], 32'h8000_0030);
        chk("wrap_l2",   bl[2], 1'b0);
        chk("wrap_d3",   bd[3], 32'h8000_0034);
        chk("wrap_l3",   bl[3], 1'b1);
        chk("wrap_r3",   br[3], 2'b00);

        // INCR across the top of the window
        burst(32'h87FF_FFFC, 8'd1, 2'b01);
        chk("edge_nbeats", nb, 2);
        chk("edge_d0",     bd[0], 32'h87FF_FFFC);
        chk("edge_r0",     br[0], 2'b00);
        chk("edge_l0",     bl[0], 1'b0);
        chk("edge_d1",     bd[1], 32'h0);
        chk("edge_r1",     br[1], 2'b10);
        chk("edge_l1",     bl[1], 1'b1);
        chk("edge_nren",   ren_q.size(), 1);

        // rready stall on beat 1 of a 2-beat burst
        issue_ar(32'h8000_0100, 8'd1, 2'b01);
        wait_rvalid("stall_beat0_seen");
        chk("stall_d0", rdata, 32'h8000_0100);
        tick();                                   // beat 0 accepted, READ
        rready = 1'b0;
        tick();                                   // beat 1 RESP
        for (int i = 0; i < 5; i++) begin
            chk("stall_rvalid", rvalid, 1'b1);
            chk("stall_rdata",  rdata,  32'h8000_0104);
            chk("stall_rlast",  rlast,  1'b1);
            chk("stall_memren", mem_ren, 1'b0);
            tick();
        end
        chk("stall_nren", ren_q.size(), 2);
        rready = 1'b1;
        #1;
        chk("stall_release_rdata", rdata, 32'h8000_0104);
        $display("R beat=1 data=%08h resp=%0d last=%0d (after stall)", rdata, rresp, rlast);
        tick();
        chk("stall_done_rvalid",  rvalid,  1'b0);
        chk("stall_done_arready", arready, 1'b1);
        tick();

        // Reserved burst type, len=2
        burst(32'h8000_0000, 8'd2, 2'b11);
        chk("rsvd_nbeats", nb, 3);
        chk("rsvd_nren",   ren_q.size(), 0);
        for (int b = 0; b < 3; b++) begin
            chk("rsvd_resp", br[b], 2'b10);
            chk("rsvd_data", bd[b], 32'h0);
            chk("rsvd_last", bl[b], (b == 2));
        end

        // WRAP with illegal length 2
        burst(32'h8000_0040, 8'd2, 2'b10);
        chk("wrapbad_nbeats", nb, 3);
        chk("wrapbad_nren",   ren_q.size(), 0);
        for (int b = 0; b < 3; b++) begin
            chk("wrapbad_resp", br[b], 2'b10);
            chk("wrapbad_last", bl[b], (b == 2));
        end

        // Reset pulse during RESP of beat 1
        issue_ar(32'h8000_0200, 8'd3, 2'b01);
        wait_rvalid("rstmid_beat0_seen");
        tick();
        wait_rvalid("rstmid_beat1_seen");
        chk("rstmid_d1", rdata, 32'h8000_0204);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rstmid_rvalid",  rvalid,  1'b0);
        chk("rstmid_rlast",   rlast,   1'b0);
        chk("rstmid_arready", arready, 1'b1);
        tick();
        burst(32'h8000_0302, 8'd1, 2'b01);
        chk("rstmid_new_nbeats", nb, 2);
        chk("rstmid_new_d0", bd[0], 32'h8000_0300);
        chk("rstmid_new_l0", bl[0], 1'b0);
        chk("rstmid_new_d1", bd[1], 32'h8000_0304);
        chk("rstmid_new_r1", br[1], 2'b00);
        chk("rstmid_new_l1", bl[1], 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
